// File: rtl/bus_pkg.sv
// Shared bus definitions: widths, service FSM states and the default peripheral address map.
package bus_pkg;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 8;
  localparam int IRQ_N  = 2;

  // Default peripheral address map, shared with the responders.
  localparam logic [ADDR_W-1:0] TIMER_ADDR = 8'hF0;
  localparam logic [ADDR_W-1:0] LED_ADDR   = 8'hC0;
  localparam logic [ADDR_W-1:0] MOUSE_ADDR = 8'hA0;
  localparam logic [ADDR_W-1:0] SEG7_ADDR  = 8'hD0;
  localparam logic [ADDR_W-1:0] PARK_DEF   = 8'hFF;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ACK   = 3'd1,
    ST_READ  = 3'd2,
    ST_WRITE = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  function automatic logic [IRQ_N-1:0] src_onehot(input logic src);
    logic [IRQ_N-1:0] oh;
    oh      = '0;
    oh[src] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/irq_priority_select.sv
// Fixed-priority pick among pending interrupts; bit 0 wins.
module irq_priority_select
  import bus_pkg::*;
(
  input  logic [IRQ_N-1:0] pending,
  output logic             valid,
  output logic             src
);

  always_comb begin
    valid = |pending;
    src   = ~pending[0] & pending[1];
  end

endmodule

// File: rtl/bus_irq_master.sv
// Interrupt-service bus initiator: ack a raised IRQ, read its source register, write it to its destination.
module bus_irq_master
  import bus_pkg::*;
#(
  parameter logic [ADDR_W-1:0] SRC0_ADDR    = TIMER_ADDR,
  parameter logic [ADDR_W-1:0] DST0_ADDR    = LED_ADDR,
  parameter logic [ADDR_W-1:0] SRC1_ADDR    = MOUSE_ADDR,
  parameter logic [ADDR_W-1:0] DST1_ADDR    = SEG7_ADDR,
  parameter int unsigned       READ_LATENCY = 2,
  parameter logic [ADDR_W-1:0] PARK_ADDR    = PARK_DEF
) (
  input  logic              CLK,
  input  logic              RESET,
  inout  wire  [DATA_W-1:0] BUS_DATA,
  output logic [ADDR_W-1:0] BUS_ADDR,
  output logic              BUS_WE,
  input  logic [IRQ_N-1:0]  BUS_INTERRUPTS_RAISE,
  output logic [IRQ_N-1:0]  BUS_INTERRUPTS_ACK,
  input  logic [IRQ_N-1:0]  IRQ_MASK,
  output logic              BUSY,
  output logic [7:0]        SERVICE_COUNT,
  output state_t            DBG_STATE
);

  localparam logic [3:0] RD_LAST = 4'(READ_LATENCY - 1);

  state_t              state_q, state_d;
  logic                src_q, src_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic [3:0]          rd_cnt_q, rd_cnt_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                we_q, we_d;
  logic [IRQ_N-1:0]    ack_q, ack_d;
  logic                busy_q, busy_d;
  logic [7:0]          count_q, count_d;

  logic                pend_valid;
  logic                pend_src;

  irq_priority_select u_sel (
    .pending (BUS_INTERRUPTS_RAISE & IRQ_MASK),
    .valid   (pend_valid),
    .src     (pend_src)
  );

  function automatic logic [ADDR_W-1:0] src_addr(input logic s);
    return s ? SRC1_ADDR : SRC0_ADDR;
  endfunction

  function automatic logic [ADDR_W-1:0] dst_addr(input logic s);
    return s ? DST1_ADDR : DST0_ADDR;
  endfunction

  always_comb begin
    state_d  = state_q;
    src_d    = src_q;
    data_d   = data_q;
    rd_cnt_d = rd_cnt_q;
    addr_d   = addr_q;
    we_d     = we_q;
    ack_d    = '0;
    count_d  = count_q;
    case (state_q)
      ST_IDLE: begin
        addr_d = PARK_ADDR;
        we_d   = 1'b0;
        if (pend_valid) begin
          src_d   = pend_src;
          ack_d   = src_onehot(pend_src);
          addr_d  = src_addr(pend_src);
          state_d = ST_ACK;
        end
      end
      ST_ACK: begin
        addr_d   = src_addr(src_q);
        rd_cnt_d = RD_LAST;
        state_d  = ST_READ;
      end
      ST_READ: begin
        if (rd_cnt_q == 4'd0) begin
          // Sample on the last read cycle; data and WE go out together next cycle.
          data_d  = BUS_DATA;
          addr_d  = dst_addr(src_q);
          we_d    = 1'b1;
          state_d = ST_WRITE;
        end else begin
          rd_cnt_d = rd_cnt_q - 4'd1;
        end
      end
      ST_WRITE: begin
        we_d    = 1'b0;
        addr_d  = PARK_ADDR;
        state_d = ST_DONE;
      end
      ST_DONE: begin
        count_d = count_q + 8'd1;
        state_d = ST_IDLE;
      end
      default: begin
        we_d    = 1'b0;
        addr_d  = PARK_ADDR;
        state_d = ST_IDLE;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q  <= ST_IDLE;
      src_q    <= 1'b0;
      data_q   <= '0;
      rd_cnt_q <= '0;
      addr_q   <= PARK_ADDR;
      we_q     <= 1'b0;
      ack_q    <= '0;
      busy_q   <= 1'b0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      src_q    <= src_d;
      data_q   <= data_d;
      rd_cnt_q <= rd_cnt_d;
      addr_q   <= addr_d;
      we_q     <= we_d;
      ack_q    <= ack_d;
      busy_q   <= busy_d;
      count_q  <= count_d;
    end
  end

  // Bus is driven only while WE is high, from the same register edge.
  assign BUS_DATA = we_q ? data_q : {DATA_W{1'bz}};

  assign BUS_ADDR           = addr_q;
  assign BUS_WE             = we_q;
  assign BUS_INTERRUPTS_ACK = ack_q;
  assign BUSY               = busy_q;
  assign SERVICE_COUNT      = count_q;
  assign DBG_STATE          = state_q;

endmodule
